// File: rtl/add6_batch_accumulator.sv
// Batch accumulator behind the 6-bit adder: sums BATCH sums per batch,
// then holds the total and sticky overflow until the consumer takes it.
//
// Ports:
//   clk, rst    clock (rising edge), synchronous active-high reset
//   clear       synchronous batch abort; drops any pending total
//   in_valid    in_sum is valid
//   in_ready    block can accept in_sum (state == ACCUM)
//   in_sum      unsigned adder result, carry in MSB
//   acc_out     running total, or the completed total while out_valid
//   count       samples accepted in the current batch
//   overflow    sticky: accumulator wrapped during this batch
//   out_valid   acc_out is a completed total (state == HOLD)
//   out_ready   consumer takes the completed total
module add6_batch_accumulator #(
  parameter int SUM_W = 7,
  parameter int ACC_W = 10,
  parameter int BATCH = 16,
  localparam int CNT_W = $clog2(BATCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BATCH - 1);

  state_t         state;
  logic [ACC_W:0] sum_ext;

  // Extra MSB is the carry-out of the ACC_W-bit add.
  assign sum_ext = {1'b0, acc_out} + (ACC_W + 1)'(in_sum);

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ACCUM;
      acc_out  <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (in_valid) begin
            acc_out  <= sum_ext[ACC_W-1:0];
            overflow <= overflow | sum_ext[ACC_W];
            if (count == LAST) begin
              count <= '0;
              state <= HOLD;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        HOLD: begin
          // Release cycle accepts nothing; next sample lands a cycle later.
          if (out_ready) begin
            state    <= ACCUM;
            acc_out  <= '0;
            overflow <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
